// File: rtl/win_banner_draw_pkg.sv
// Shared types and sizes for the "YOU WIN" banner renderer.
// The ROM is 65 bits wide and 16 rows deep.
package win_banner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      SHOW   = 2'd2
   } banner_state_t;

   localparam int BANNER_W = 65;
   localparam int BANNER_H = 16;
   localparam int ROW_AW   = 4;
   localparam int BIT_AW   = 7;
   localparam int REV_W    = 7;
   localparam int REV_MAX  = 64;

endpackage

// File: rtl/win_banner_draw_if.sv
// Raster, ROM and pixel signals between the banner renderer and its surroundings.
// The slave modport is the renderer; the master modport is the video/game side.
interface win_banner_draw_if;

   logic                                show;
   logic                                frame_start;
   logic [9:0]                          DrawX;
   logic [9:0]                          DrawY;
   logic [win_banner_pkg::ROW_AW-1:0]   rom_addr;
   logic [win_banner_pkg::BANNER_W-1:0] rom_data;
   logic                                win_pixel;
   logic                                banner_busy;

   modport master (
      output show, frame_start, DrawX, DrawY, rom_data,
      input  rom_addr, win_pixel, banner_busy
   );

   modport slave (
      input  show, frame_start, DrawX, DrawY, rom_data,
      output rom_addr, win_pixel, banner_busy
   );

endinterface

// File: rtl/win_banner_draw_pipe.sv
// Two-stage raster pipeline: box test and ROM row/bit selection, then the registered pixel.
// Pixel appears exactly two clocks after DrawX/DrawY.
module win_banner_pipe
   import win_banner_pkg::*;
#(
   parameter int X0          = 190,
   parameter int Y0          = 208,
   parameter int SCALE_SHIFT = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [9:0]          draw_x_i,
   input  logic [9:0]          draw_y_i,
   input  banner_state_t       state_i,
   input  logic [REV_W-1:0]    reveal_rows_i,
   input  logic                visible_i,
   input  logic [BANNER_W-1:0] rom_data_i,
   output logic [ROW_AW-1:0]   rom_addr_o,
   output logic                win_pixel_o
);

   localparam logic [9:0] X_BEG = 10'(X0);
   localparam logic [9:0] Y_BEG = 10'(Y0);
   localparam logic [9:0] X_END = 10'(X0 + (BANNER_W << SCALE_SHIFT));
   localparam logic [9:0] Y_END = 10'(Y0 + (BANNER_H << SCALE_SHIFT));

   logic [9:0]        lx, ly;
   logic              in_box, in_rev;
   logic [BIT_AW-1:0] col, bit_sel;
   logic [ROW_AW-1:0] row;

   logic [ROW_AW-1:0] rom_addr_p1_q;
   logic [BIT_AW-1:0] bit_p1_q;
   logic              en_p1_q;
   logic              pix_p2_q;

   assign lx      = draw_x_i - X_BEG;
   assign ly      = draw_y_i - Y_BEG;
   assign in_box  = (draw_x_i >= X_BEG) && (draw_x_i < X_END) &&
                    (draw_y_i >= Y_BEG) && (draw_y_i < Y_END);
   assign col     = BIT_AW'(lx >> SCALE_SHIFT);
   assign bit_sel = BIT_AW'(BANNER_W - 1) - col;
   assign row     = ROW_AW'(ly >> SCALE_SHIFT);

   // Reveal masks by screen row, so compare the unscaled offset.
   always_comb begin
      in_rev = 1'b0;
      case (state_i)
         REVEAL:  in_rev = (ly < {3'b000, reveal_rows_i});
         SHOW:    in_rev = 1'b1;
         default: in_rev = 1'b0;
      endcase
   end

   // S1: ROM row address, bit index and pixel enable.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr_p1_q <= '0;
         bit_p1_q      <= '0;
         en_p1_q       <= 1'b0;
      end else begin
         rom_addr_p1_q <= in_box ? row : '0;
         bit_p1_q      <= in_box ? bit_sel : '0;
         en_p1_q       <= in_box & in_rev & visible_i;
      end
   end

   // S2: ROM data has settled for the S1 address; pick the bit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_p2_q <= 1'b0;
      end else begin
         pix_p2_q <= en_p1_q & rom_data_i[bit_p1_q];
      end
   end

   assign rom_addr_o  = rom_addr_p1_q;
   assign win_pixel_o = pix_p2_q;

endmodule

// File: rtl/win_banner_draw.sv
// "YOU WIN" banner renderer: reveal/blink FSM driven by frame_start, plus the raster pipeline.
// The bitmap ROM sits outside; it returns rom_data combinationally from rom_addr.
module win_banner_draw
   import win_banner_pkg::*;
#(
   parameter int X0           = 190,
   parameter int Y0           = 208,
   parameter int SCALE_SHIFT  = 2,
   parameter int REVEAL_STEP  = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic             Clk,
   input  logic             Reset,
   win_banner_draw_if.slave bus
);

   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   banner_state_t      state_q, state_d;
   logic [REV_W-1:0]   reveal_q, reveal_d, rev_next;
   logic [REV_W:0]     rev_sum;
   logic [BLINK_W-1:0] blink_q, blink_d;
   logic               visible_q, visible_d;
   logic               busy_q;

   assign rev_sum  = {1'b0, reveal_q} + (REV_W+1)'(REVEAL_STEP);
   assign rev_next = (rev_sum >= (REV_W+1)'(REV_MAX)) ? REV_W'(REV_MAX) : rev_sum[REV_W-1:0];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         reveal_q  <= '0;
         blink_q   <= '0;
         visible_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         reveal_q  <= reveal_d;
         blink_q   <= blink_d;
         visible_q <= visible_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   // Dropping show always wins over a coincident frame_start.
   always_comb begin
      state_d   = state_q;
      reveal_d  = reveal_q;
      blink_d   = blink_q;
      visible_d = visible_q;
      case (state_q)
         IDLE: begin
            if (bus.show && bus.frame_start) begin
               state_d   = REVEAL;
               reveal_d  = '0;
               blink_d   = '0;
               visible_d = 1'b1;
            end
         end
         REVEAL: begin
            if (!bus.show) begin
               state_d = IDLE;
            end else if (bus.frame_start) begin
               reveal_d = rev_next;
               if (rev_next == REV_W'(REV_MAX)) state_d = SHOW;
            end
         end
         SHOW: begin
            if (!bus.show) begin
               state_d = IDLE;
            end else if (bus.frame_start) begin
               if (blink_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                  blink_d   = '0;
                  visible_d = ~visible_q;
               end else begin
                  blink_d = blink_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   win_banner_pipe #(
      .X0          (X0),
      .Y0          (Y0),
      .SCALE_SHIFT (SCALE_SHIFT)
   ) u_pipe (
      .Clk           (Clk),
      .Reset         (Reset),
      .draw_x_i      (bus.DrawX),
      .draw_y_i      (bus.DrawY),
      .state_i       (state_q),
      .reveal_rows_i (reveal_q),
      .visible_i     (visible_q),
      .rom_data_i    (bus.rom_data),
      .rom_addr_o    (bus.rom_addr),
      .win_pixel_o   (bus.win_pixel)
   );

   assign bus.banner_busy = busy_q;

endmodule

// File: tb/tb_win_banner_draw.sv
// Bench for win_banner_draw: frame-level model of reveal/blink and bitmap lookup, checked every cycle,
// plus directed literal checks.
module tb_win_banner_draw;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   win_banner_draw_if bus ();

   win_banner_draw #(
      .X0 (190), .Y0 (208), .SCALE_SHIFT (2), .REVEAL_STEP (2), .BLINK_FRAMES (30)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [64:0] rom [16];
   assign bus.rom_data = rom[bus.rom_addr];

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: mode 0 idle, 1 revealing, 2 showing; rr = revealed screen rows.
   typedef struct {
      int mode;
      int rr;
      int bc;
      bit vis;
   } mstate_t;

   mstate_t m = '{0, 0, 0, 1'b0};
   bit e_d1 = 1'b0, e_px = 1'b0, e_busy = 1'b0;
   int e_addr = 0;

   function automatic bit in_box(int x, int y);
      return (x >= 190) && (x < 190 + 65 * 4) && (y >= 208) && (y < 208 + 16 * 4);
   endfunction

   function automatic bit pix_on(int x, int y, mstate_t s);
      int r, c;
      if (!in_box(x, y) || !s.vis || s.mode == 0) return 1'b0;
      if (s.mode == 1 && (y - 208) >= s.rr) return 1'b0;
      r = (y - 208) / 4;
      c = (x - 190) / 4;
      return rom[r][64 - c];
   endfunction

   function automatic mstate_t model_next(mstate_t s, bit show, bit fs);
      mstate_t n = s;
      if (s.mode == 0) begin
         if (show && fs) n = '{1, 0, 0, 1'b1};
      end else if (!show) begin
         n.mode = 0;
      end else if (fs && s.mode == 1) begin
         n.rr = (s.rr + 2 > 64) ? 64 : s.rr + 2;
         if (n.rr == 64) n.mode = 2;
      end else if (fs) begin
         n.bc = (s.bc + 1) % 30;
         if (n.bc == 0) n.vis = !s.vis;
      end
      return n;
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         m      <= '{0, 0, 0, 1'b0};
         e_d1   <= 1'b0;
         e_px   <= 1'b0;
         e_addr <= 0;
         e_busy <= 1'b0;
      end else begin
         m      <= model_next(m, bus.show, bus.frame_start);
         e_busy <= (model_next(m, bus.show, bus.frame_start).mode != 0);
         e_d1   <= pix_on(bus.DrawX, bus.DrawY, m);
         e_px   <= e_d1;
         e_addr <= in_box(bus.DrawX, bus.DrawY) ? (bus.DrawY - 208) / 4 : 0;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         check("win_pixel", 32'(bus.win_pixel), 32'(e_px));
         check("banner_busy", 32'(bus.banner_busy), 32'(e_busy));
         check("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      step();
   endtask

   task automatic at(input int x, input int y);
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
   endtask

   task automatic sweep_row(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) begin
         at(x, y);
         step();
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++)
         for (int b = 0; b < 65; b++)
            rom[r][b] = (b == 64) || (((b + r) % 3) == 0);

      Reset = 1'b1;
      bus.show = 1'b0;
      bus.frame_start = 1'b0;
      at(0, 0);
      step();
      chk_en = 1'b1;
      repeat (2) step();

      // Reset released, show high without a frame: must stay idle.
      Reset = 1'b0;
      bus.show = 1'b1;
      at(190, 216);
      repeat (4) step();
      check("idle_busy", 32'(bus.banner_busy), 0);
      check("idle_pixel", 32'(bus.win_pixel), 0);

      frame();
      check("enter_reveal_busy", 32'(bus.banner_busy), 1);
      repeat (32) frame();
      check("model_rr_full", 32'(m.rr), 64);
      check("model_mode_show", 32'(m.mode), 2);
      check("show_busy", 32'(bus.banner_busy), 1);

      at(190, 216);
      step();
      check("rom_addr_row2", 32'(bus.rom_addr), 2);
      step();
      check("pixel_bit64", 32'(bus.win_pixel), 1);
      at(198, 216);
      repeat (2) step();
      check("pixel_bit62", 32'(bus.win_pixel), 0);
      at(450, 216);
      repeat (2) step();
      check("pixel_x450", 32'(bus.win_pixel), 0);
      at(189, 216);
      repeat (2) step();
      check("pixel_x189", 32'(bus.win_pixel), 0);

      sweep_row(208, 186, 454);
      sweep_row(219, 186, 454);
      sweep_row(271, 186, 454);
      sweep_row(272, 186, 200);
      sweep_row(207, 186, 200);

      // Blink: 30 frames off, 30 frames on.
      repeat (30) frame();
      check("model_vis_off", 32'(m.vis), 0);
      at(190, 216);
      repeat (2) step();
      check("blink_off_pixel", 32'(bus.win_pixel), 0);
      sweep_row(216, 186, 260);
      repeat (30) frame();
      at(190, 216);
      repeat (2) step();
      check("blink_on_pixel", 32'(bus.win_pixel), 1);

      // Partial reveal to 10 rows.
      bus.show = 1'b0;
      step();
      check("leave_busy", 32'(bus.banner_busy), 0);
      bus.show = 1'b1;
      frame();
      repeat (5) frame();
      check("model_rr_10", 32'(m.rr), 10);
      at(190, 217);
      repeat (2) step();
      check("reveal_ly9", 32'(bus.win_pixel), 1);
      at(190, 218);
      repeat (2) step();
      check("reveal_ly10", 32'(bus.win_pixel), 0);
      for (int y = 206; y < 222; y++) sweep_row(y, 188, 200);

      // show drop coincident with frame_start.
      bus.show = 1'b0;
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      check("drop_busy", 32'(bus.banner_busy), 0);
      check("model_rr_kept", 32'(m.rr), 10);
      step();

      // Reset in SHOW on a lit pixel.
      bus.show = 1'b1;
      repeat (33) frame();
      at(190, 216);
      repeat (2) step();
      check("pre_reset_pixel", 32'(bus.win_pixel), 1);
      Reset = 1'b1;
      step();
      check("reset_pixel", 32'(bus.win_pixel), 0);
      check("reset_busy", 32'(bus.banner_busy), 0);
      check("reset_rom_addr", 32'(bus.rom_addr), 0);
      Reset = 1'b0;
      repeat (4) step();
      check("post_reset_pixel", 32'(bus.win_pixel), 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
